// File: rtl/serial_div_pkg.sv
// Shared types and arithmetic for the serial divisibility scheduler.
//   state_t  : scheduler FSM states (IDLE, SHIFT, DONE)
//   mod_step : one MSB-first remainder step, (2*rem + bit) mod divisor,
//              built from a shift and a single conditional subtract.
package serial_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MOD_W = 32;

  // rem < divisor on entry, so 2*rem + bit < 2*divisor and one subtract
  // always lands back in range; only RW+1 bits of the shift carry value.
  function automatic logic [MOD_W-1:0] mod_step(
    input logic [MOD_W-1:0] rem,
    input logic             bit_in,
    input logic [MOD_W-1:0] divisor
  );
    logic [MOD_W-1:0] twice;
    twice = {rem[MOD_W-2:0], bit_in};
    if (twice >= divisor) begin
      mod_step = twice - divisor;
    end else begin
      mod_step = twice;
    end
  endfunction

endpackage

// File: rtl/serial_mod_engine.sv
// Bit-serial mod-DIVISOR remainder engine.
// Ports:
//   clk, rst : clock, synchronous active-high reset (remainder -> 0)
//   clear    : zero the remainder (start of a new word)
//   step     : fold new_bit into the remainder this cycle
//   new_bit  : next word bit, MSB first
//   rem      : remainder including this cycle's step, i.e. the value the
//              register holds after the coming clock edge
module serial_mod_engine
  import serial_div_pkg::*;
#(
  parameter  int DIVISOR = 5,
  localparam int RW      = $clog2(DIVISOR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  input  logic          new_bit,
  output logic [RW-1:0] rem
);

  logic [RW-1:0] rem_q;
  logic [RW-1:0] rem_step;

  always_comb begin
    rem_step = RW'(mod_step(MOD_W'(rem_q), new_bit, MOD_W'(DIVISOR)));
    rem      = step ? rem_step : rem_q;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rem_q <= '0;
    end else if (step) begin
      rem_q <= rem_step;
    end
  end

endmodule

// File: rtl/serial_divisibility_scheduler.sv
// Shares one serial mod-DIVISOR engine between N_REQ requesters.
// A round-robin arbiter accepts one WIDTH-bit word while idle, the word is
// shifted MSB-first through the engine, and the remainder, divisibility flag
// and owning requester id are returned on a valid/ready result channel.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   req_valid  : per-requester request valid
//   req_data   : word i at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot accept, only while idle
//   res_valid / res_ready : result handshake
//   res_id     : requester that owns the result
//   res_div    : word % DIVISOR == 0
//   res_rem    : word % DIVISOR
// Build option:
//   SERIAL_DIV_LEADING_ZERO_SKIP_EN : start shifting at the word's most
//   significant 1 (all-zero words finish immediately). Results are the same,
//   only latency changes.
module serial_divisibility_scheduler
  import serial_div_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int WIDTH   = 8,
  parameter  int DIVISOR = 5,
  localparam int RW      = $clog2(DIVISOR),
  localparam int IW      = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [IW-1:0]          res_id,
  output logic                   res_div,
  output logic [RW-1:0]          res_rem
);

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [IW-1:0]    rr;
  logic [IW-1:0]    grant;
  logic [IW-1:0]    rr_next;
  logic [IW-1:0]    idx;
  logic             found;
  logic             accept;
  logic [WIDTH-1:0] words [N_REQ];
  logic [WIDTH-1:0] word;
  logic [IW-1:0]    id_q;
  logic [CW-1:0]    cnt;
  logic             eng_clear;
  logic             eng_step;
  logic             eng_bit;
  logic [RW-1:0]    eng_rem;

`ifdef SERIAL_DIV_LEADING_ZERO_SKIP_EN
  function automatic logic [CW-1:0] msb_index(input logic [WIDTH-1:0] w);
    msb_index = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w[i]) msb_index = CW'(i);
    end
  endfunction
`endif

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      words[i] = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Arbiter: first valid requester at or after the rr pointer, with wrap.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(rr) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    accept    = (state == IDLE) && found;
    rr_next   = (grant == IW'(N_REQ - 1)) ? '0 : grant + 1'b1;
    req_ready = '0;
    if (accept) req_ready[grant] = 1'b1;
  end

  always_comb begin
    eng_clear = accept;
    eng_step  = (state == SHIFT);
    eng_bit   = word[cnt];
  end

  serial_mod_engine #(
    .DIVISOR (DIVISOR)
  ) u_engine (
    .clk     (clk),
    .rst     (rst),
    .clear   (eng_clear),
    .step    (eng_step),
    .new_bit (eng_bit),
    .rem     (eng_rem)
  );

  // Accept stage: latch word, owner id and starting bit index.
  always_ff @(posedge clk) begin
    if (accept) begin
      word <= words[grant];
      id_q <= grant;
`ifdef SERIAL_DIV_LEADING_ZERO_SKIP_EN
      cnt  <= msb_index(words[grant]);
`else
      cnt  <= CW'(WIDTH - 1);
`endif
    end else if (state == SHIFT) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Control FSM with registered result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr        <= '0;
      res_valid <= 1'b0;
      res_id    <= '0;
      res_div   <= 1'b0;
      res_rem   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rr    <= rr_next;
            state <= SHIFT;
`ifdef SERIAL_DIV_LEADING_ZERO_SKIP_EN
            if (words[grant] == '0) begin
              state     <= DONE;
              res_valid <= 1'b1;
              res_id    <= grant;
              res_div   <= 1'b1;
              res_rem   <= '0;
            end
`endif
          end
        end
        SHIFT: begin
          // eng_rem already includes the final bit folded in this cycle.
          if (cnt == '0) begin
            state     <= DONE;
            res_valid <= 1'b1;
            res_id    <= id_q;
            res_div   <= (eng_rem == '0);
            res_rem   <= eng_rem;
          end
        end
        DONE: begin
          if (res_ready) begin
            state     <= IDLE;
            res_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
